// File: rtl/time_keeper_pkg.sv
// Shared state encodings, BCD limits and BCD increment helpers for the time keeper.
package time_keeper_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } state_t;

    localparam logic [3:0] SEC_MAX_T = 4'd5;
    localparam logic [3:0] MIN_MAX_T = 4'd5;
    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [7:0] HR_MAX    = 8'h23;

    // Two-digit BCD increment wrapping to 00 after {max_t, 9}.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [3:0] max_t);
        logic [7:0] r;
        if (v[3:0] == DIGIT_MAX) begin
            if (v[7:4] == max_t) r = 8'h00;
            else                 r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] hr_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == HR_MAX) r = 8'h00;
        else             r = bcd_inc(v, 4'd2);
        return r;
    endfunction

endpackage

// File: rtl/time_keeper_tick_sync.sv
// Brings the asynchronous 1 Hz square wave into clk and turns each rising edge into a one-cycle tick.
module tick_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_1,
    output logic tick,
    output logic sync_level
);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic [SYNC_STAGES-1:0] vld_pipe;
    logic                   prev;
    logic                   armed;

    assign sync_level = sync_ff[SYNC_STAGES-1];
    assign tick       = sync_level & ~prev & armed;

    // vld_pipe marks when sync_level carries a real sample rather than the
    // reset zero, so a clk_1 held high across reset release cannot arm a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff  <= '0;
            vld_pipe <= '0;
            prev     <= 1'b0;
            armed    <= 1'b0;
        end else begin
            sync_ff  <= {sync_ff[SYNC_STAGES-2:0], clk_1};
            vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
            prev     <= sync_level;
            if (vld_pipe[SYNC_STAGES-1] && !sync_level)
                armed <= 1'b1;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// 24-hour BCD clock with two-step set mode, hourly chime and set-mode blink level.
module time_keeper
    import time_keeper_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_1,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [3:0] hr_t,
    output logic [3:0] hr_u,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic [1:0] set_state,
    output logic       chime,
    output logic       blink
);

    localparam logic [7:0] SEC_LAST = {SEC_MAX_T, DIGIT_MAX};
    localparam logic [7:0] MIN_LAST = {MIN_MAX_T, DIGIT_MAX};

    logic       tick;
    logic       sync_level;
    state_t     state;
    logic [7:0] hr, mins, sec;

    tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
        .clk       (clk),
        .rst       (rst),
        .clk_1     (clk_1),
        .tick      (tick),
        .sync_level(sync_level)
    );

    assign {hr_t, hr_u}   = hr;
    assign {min_t, min_u} = mins;
    assign {sec_t, sec_u} = sec;
    assign set_state      = state;
    assign blink          = (state != ST_RUN) & sync_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            hr    <= 8'h00;
            mins  <= 8'h00;
            sec   <= 8'h00;
            chime <= 1'b0;
        end else begin
            chime <= 1'b0;
            unique case (state)
                ST_RUN: begin
                    if (tick) begin
                        sec <= bcd_inc(sec, SEC_MAX_T);
                        if (sec == SEC_LAST) begin
                            mins <= bcd_inc(mins, MIN_MAX_T);
                            if (mins == MIN_LAST) begin
                                hr    <= hr_inc(hr);
                                chime <= 1'b1;
                            end
                        end
                    end
                    if (mode_btn) state <= ST_SET_HR;
                end
                ST_SET_HR: begin
                    if (inc_btn)  hr    <= hr_inc(hr);
                    if (mode_btn) state <= ST_SET_MIN;
                end
                ST_SET_MIN: begin
                    if (inc_btn) mins <= bcd_inc(mins, MIN_MAX_T);
                    if (mode_btn) begin
                        sec   <= 8'h00;
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Consumes the 1 Hz square wave from the board frequency divider.
- Maintains a 24-hour hh:mm:ss time in BCD and provides a two-step user set mode driven by debounced button pulses.
- Feeds the display mux with six BCD digits and a set-mode blink level.
- Feeds the sound block with a one-cycle hourly chime pulse.
- Sits directly downstream of the divider's 1 Hz output; whole block runs on the 100 MHz system clock.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising clk_1 into the clk domain (minimum 2).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  synchronous, active-high reset.
- clk_1  input  1  1 Hz 50% square wave from the divider; treated as asynchronous data.
- mode_btn  input  1  single-cycle pulse, debounced upstream.
- inc_btn  input  1  single-cycle pulse, debounced upstream.
- hr_t, hr_u, min_t, min_u, sec_t, sec_u  output  4 each  BCD digits (tens, units).
- set_state  output  2  0=RUN, 1=SET_HR, 2=SET_MIN.
- chime  output  1  one-cycle pulse at each top of hour.
- blink  output  1  synchronised clk_1 level in set states, 0 in RUN.

Interface decision: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Reset (rst sampled high on a clk edge):
  - All digits 0, so time reads 00:00:00.
  - set_state=RUN, chime=0, blink=0.
  - Synchroniser flops cleared to 0; armed flag cleared to 0.
- Tick generation:
  - clk_1 passes through SYNC_STAGES flops, then through an edge register.
  - tick = sync_out & ~prev & armed (combinational, one cycle wide).
  - armed sets on the first cycle sync_out is 0 after reset. A clk_1 that is already high at reset release therefore produces no tick.
- Latency: with SYNC_STAGES=2, if clk_1 rises before edge k, the new digits are visible after edge k+2.
- RUN state, on tick:
  - sec_u increments. 9 wraps to 0 with carry into sec_t; sec_t 5 wraps to 0 with carry into minutes.
  - Minutes follow the same pattern.
  - Hours 23 wrap to 00; hr_u wraps at 9 except at 23.
  - No digit ever holds an illegal BCD value.
- Chime:
  - Registered, high for exactly the one cycle in which mm:ss first shows 00:00 after a RUN rollover.
  - This includes 23:59:59 → 00:00:00.
  - Never asserted by set-mode edits or by reset.
- Mode state machine:
  - mode_btn advances RUN → SET_HR → SET_MIN → RUN.
  - The SET_MIN → RUN transition also clears seconds to 00.
- Set states:
  - Ticks are ignored; time is frozen.
  - inc_btn increments the selected field only, with no carry. Hours 23→00; minutes 59→00.
  - inc_btn in RUN is ignored.
- Simultaneous events:
  - mode_btn + tick in RUN: the tick is applied and the state moves to SET_HR.
  - mode_btn + inc_btn in a set state: the increment applies to the current field, then the state advances.
  - mode_btn + inc_btn in SET_MIN: minutes increment, seconds clear, state becomes RUN.
- Reset mid-operation (any state, including during set): next cycle shows the full reset values above.
- blink: equals sync_out in SET_HR and SET_MIN; 0 in RUN.

Decomposition:
- Shared package holds:
  - State encodings ST_RUN=2'd0, ST_SET_HR=2'd1, ST_SET_MIN=2'd2.
  - BCD limit constants: SEC_MAX_T=5, MIN_MAX_T=5, HR_MAX=23, DIGIT_MAX=9.
- One sub-module: tick_sync.
  - Contains the SYNC_STAGES synchroniser, edge register and armed flag.
  - Outputs tick and sync_level.
- Counters and FSM stay in time_keeper.

Test Plan:
- Reset scenario: hold clk_1 high through reset and release. Required: no tick and digits 00:00:00 until clk_1 goes low then high; after that rise, 00:00:01 appears exactly 2 clk edges later; chime stays 0 throughout.
- Seconds/minute carry: apply 59 clk_1 periods → 00:00:59. Apply 1 more → 00:01:00, all other digits correct, chime=0.
- Day rollover: set 23:59 via SET_HR (23 inc) and SET_MIN (59 inc), return to RUN (seconds 00), then apply 60 periods. Required: 00:00:00 and chime high for exactly 1 cycle.
- Set-mode wrap: in SET_HR at 23, one inc → 00 with minutes unchanged. Clock clk_1 for 5 periods in SET_MIN → time unchanged, and blink tracks clk_1 delayed by 2 cycles.
- Simultaneous event: mode_btn on the tick cycle in RUN at 00:00:10. Required: 00:00:11 and set_state=1 on the same edge.
- Mid-set reset: rst during SET_MIN at 12:34. Required: next cycle shows 00:00:00, set_state=0, chime=0, blink=0.
